adc128s_fc: RTL and testbench
=============================

# adc128s_fc

Behavioral, clocked model of an 8-channel, 12-bit SPI A/D converter (ADC128S-style) used in Segway system benches to feed the left/right load cells, the steering potentiometer and the battery voltage to the Segway's A2D interface. It acts as an SPI slave on 16-bit frames. Each frame's MOSI word selects a channel, and the conversion for that channel is returned on MISO during the *next* frame.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; same domain as the SPI master
- `rst_n`  in  1  asynchronous active-low reset
- `SS_n`  in  1  slave select, active low; frame boundary
- `SCLK`  in  1  serial clock from master; idles high
- `MOSI`  in  1  serial command from master, MSB first
- `MISO`  out  1  serial data to master, MSB first
- `ld_cell_lft`  in  12  analog value reported on channel 0
- `ld_cell_rght`  in  12  analog value reported on channel 4
- `steerPot`  in  12  analog value reported on channel 5
- `batt`  in  12  analog value reported on channel 6

## Operation
- `SS_n`, `SCLK` and `MOSI` are sampled into `clk` through 2-flop synchronizers.
- Edge detection uses the synchronized versions against one further registered copy.
- Frame start is detected on the `SS_n` falling edge:
  - `tx_shft[15:0]` loads `{4'h0, value(chan)}`, where `chan` is the channel latched at the end of the previous frame.
  - The rising-edge seen flag is cleared.
- On each `SCLK` rising edge while `SS_n` is low:
  - `rx_shft <= {rx_shft[14:0], MOSI_sync}`.
  - The rising-edge seen flag is set.
- On each `SCLK` falling edge while `SS_n` is low, *and only if a rising edge has already occurred in this frame*:
  - `tx_shft <= {tx_shft[14:0], 1'b0}`.
  - The first falling edge after `SS_n` falls is the master's front porch and is ignored.
- Frame end is detected on the `SS_n` rising edge: `chan <= rx_shft[13:11]`. All other command bits are ignored.
- `MISO` = `tx_shft[15]` at all times.
- Channel map:
  - 0 → `ld_cell_lft`
  - 4 → `ld_cell_rght`
  - 5 → `steerPot`
  - 6 → `batt`
  - 1, 2, 3 and 7 → `12'h000`
- Analog inputs are sampled at the frame-start instant. Changes during a frame do not affect that frame.
- Frames with other than 16 rising edges are not errors:
  - The channel field is taken from whatever `rx_shft` holds at `SS_n` rise.
  - Surplus shifts fill `MISO` with zeros.
- Reset values: `tx_shft` = 0 (so `MISO` = 0), `rx_shft` = 0, `chan` = 0, synchronizers = 1 (idle-high), rising-edge seen flag = 0.
- Reset mid-frame aborts the frame. The next complete frame after reset returns channel 0 data.

## Timing
- `MISO` bit 15 is valid 3 `clk` cycles after `SS_n` falls.
- Each subsequent bit is valid 3 `clk` cycles after the corresponding `SCLK` fall.
- The master's `SCLK` half-period must be ≥4 `clk` cycles. The Segway master uses 16.
- Response latency is one frame:
  - Frame N carries the command.
  - Frame N+1 returns that command's result and simultaneously carries the next command.
- A read of a given channel therefore needs two frames. A 2-frame read issues the same channel twice.
- Back-to-back frames require `SS_n` high for ≥3 `clk` cycles between them so both edges are detected.

## Structure
- Shared package `adc_pkg`:
  - channel constants `CH_LD_LFT=3'd0`, `CH_LD_RGHT=3'd4`, `CH_STEER=3'd5`, `CH_BATT=3'd6`
  - frame length `ADC_FRAME_BITS=16`
  - channel field position `[13:11]`
- One sub-module is natural: `spi_sync_edge`. It contains the 2-flop synchronizer plus rise/fall detect, instantiated for `SS_n` and `SCLK`; `MOSI` only needs the synchronizer.
- The channel mux is combinational in the top.

## Test plan
- Reset, then one frame commanding channel 0 → `MISO` returns `16'h0000`, because the reset channel is 0 and the first frame returns data latched at frame start.
- `ld_cell_lft`=`12'h300`; frame cmd ch0 then frame cmd ch0 → second frame returns `16'h0300`.
- `steerPot`=`12'hE00`; frame cmd ch5 (`MOSI` word `16'h2800`) then any frame → returns `16'h0E00`. Repeat with `12'h100`, `12'h200`, `12'hA00` and `12'hF00` → values echoed exactly.
- Round-robin ch0, 4, 5, 6 with `ld_cell_lft`=`12'h300`, `ld_cell_rght`=`12'h300`, `steerPot`=`12'h800`, `batt`=`12'hFFF`:
  - each frame returns the previous frame's channel
  - check the sequence `0x300`, `0x300`, `0x800`, `0xFFF`
- Change `batt` from `12'h800` to `12'h900` mid-frame → that frame still returns `12'h800`; the next ch6 read returns `12'h900`.
- Assert `rst_n` low halfway through a frame → `MISO`=0 immediately; after release, the next full frame returns ch0 data.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC128S-style SPI converter model.
// Channel map, frame geometry and the tx-word formatter live here.
package adc_pkg;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_DATA_BITS  = 12;
  localparam int unsigned CH_FIELD_MSB   = 13;
  localparam int unsigned CH_FIELD_LSB   = 11;

  typedef logic [2:0]               chan_t;
  typedef logic [ADC_DATA_BITS-1:0] sample_t;
  typedef logic [ADC_FRAME_BITS-1:0] frame_t;

  localparam chan_t CH_LD_LFT  = 3'd0;
  localparam chan_t CH_LD_RGHT = 3'd4;
  localparam chan_t CH_STEER   = 3'd5;
  localparam chan_t CH_BATT    = 3'd6;

  // Conversion result is right-justified with four leading zeros.
  function automatic frame_t frame_word(input sample_t s);
    return {4'h0, s};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an idle-high SPI control line, plus rise/fall
// detection against one further registered copy.
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/adc128s_fc.sv
// Clocked SPI-slave model of an 8-channel 12-bit ADC. The channel commanded in
// one 16-bit frame is converted and shifted out on MISO during the next frame.
module adc128s_fc
  import adc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  logic    w_ss_rise;
  logic    w_ss_fall;
  logic    w_sclk_rise;
  logic    w_sclk_fall;
  sample_t w_chan_val;

  logic    r_mosi_meta;
  logic    r_mosi_sync;
  logic    r_in_frame;
  logic    r_rise_seen;
  chan_t   r_chan;
  frame_t  r_tx_shft;
  frame_t  r_rx_shft;

  spi_sync_edge u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SS_n),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  spi_sync_edge u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SCLK),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // MOSI shares the SCLK sync latency, so it lines up with the detected rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_meta <= 1'b1;
      r_mosi_sync <= 1'b1;
    end else begin
      r_mosi_meta <= MOSI;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  always_comb begin
    w_chan_val = '0;
    case (r_chan)
      CH_LD_LFT:  w_chan_val = ld_cell_lft;
      CH_LD_RGHT: w_chan_val = ld_cell_rght;
      CH_STEER:   w_chan_val = steerPot;
      CH_BATT:    w_chan_val = batt;
      default:    w_chan_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_frame <= 1'b0;
    end else if (w_ss_fall) begin
      r_in_frame <= 1'b1;
    end else if (w_ss_rise) begin
      r_in_frame <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise_seen <= 1'b0;
    end else if (w_ss_fall) begin
      r_rise_seen <= 1'b0;
    end else if (r_in_frame && w_sclk_rise) begin
      r_rise_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shft <= '0;
    end else if (r_in_frame && w_sclk_rise) begin
      r_rx_shft <= {r_rx_shft[ADC_FRAME_BITS-2:0], r_mosi_sync};
    end
  end

  // The leading SCLK fall is the master's front porch and must not shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shft <= '0;
    end else if (w_ss_fall) begin
      r_tx_shft <= frame_word(w_chan_val);
    end else if (r_in_frame && w_sclk_fall && r_rise_seen) begin
      r_tx_shft <= {r_tx_shft[ADC_FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan <= CH_LD_LFT;
    end else if (w_ss_rise) begin
      r_chan <= r_rx_shft[CH_FIELD_MSB:CH_FIELD_LSB];
    end
  end

  assign MISO = r_tx_shft[ADC_FRAME_BITS-1];

endmodule

// File: tb/tb_adc128s_fc.sv
// Scoreboard bench for adc128s_fc: a bit-banged SPI master issues frames and
// queues the hand-computed reply; a monitor compares each received word.
module tb_adc128s_fc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [11:0] ld_cell_lft;
  logic [11:0] ld_cell_rght;
  logic [11:0] steerPot;
  logic [11:0] batt;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic [15:0] rx_q[$];

  adc128s_fc u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SS_n        (SS_n),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .ld_cell_lft (ld_cell_lft),
    .ld_cell_rght(ld_cell_rght),
    .steerPot    (steerPot),
    .batt        (batt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  // One 16-bit frame, SCLK half-period 16 clk. MISO sampled just before each rise.
  task automatic frame(input logic [2:0] ch, input logic [15:0] exp, input string nm,
                       input bit mid_en = 1'b0, input logic [11:0] mid_val = 12'h000);
    logic [15:0] cmd;
    logic [15:0] rx;
    cmd = {2'b00, ch, 11'h000};
    rx  = '0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 15; i >= 0; i--) begin
      SCLK = 1'b0;
      MOSI = cmd[i];
      repeat (16) @(negedge clk);
      rx[i] = MISO;
      SCLK = 1'b1;
      if (mid_en && i == 8) batt = mid_val;
      repeat (16) @(negedge clk);
    end
    SS_n = 1'b1;
    repeat (16) @(negedge clk);
    rx_q.push_back(rx);
  endtask

  initial begin : monitor
    logic [15:0] act;
    forever begin
      @(posedge clk);
      while (rx_q.size() > 0) begin
        act = rx_q.pop_front();
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: got 0x%04h expected none", act);
        end else begin
          check(name_q.pop_front(), act, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    logic [11:0] steer_vals[5];
    steer_vals = '{12'hE00, 12'h100, 12'h200, 12'hA00, 12'hF00};

    rst_n        = 1'b0;
    SS_n         = 1'b1;
    SCLK         = 1'b1;
    MOSI         = 1'b0;
    ld_cell_lft  = 12'h000;
    ld_cell_rght = 12'h000;
    steerPot     = 12'h000;
    batt         = 12'h000;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_miso", {15'h0, MISO}, 16'h0000);

    frame(3'd0, 16'h0000, "first_frame_ch0");

    ld_cell_lft = 12'h300;
    frame(3'd0, 16'h0300, "lft_ch0_a");
    frame(3'd0, 16'h0300, "lft_ch0_b");

    foreach (steer_vals[k]) begin
      steerPot = steer_vals[k];
      frame(3'd5, 16'h0300, $sformatf("steer_cmd_%0d", k));
      frame(3'd0, {4'h0, steer_vals[k]}, $sformatf("steer_read_%0h", steer_vals[k]));
    end

    ld_cell_rght = 12'h300;
    steerPot     = 12'h800;
    batt         = 12'hFFF;
    frame(3'd0, 16'h0300, "rr_pre_ch0");
    frame(3'd4, 16'h0300, "rr_ch0");
    frame(3'd5, 16'h0300, "rr_ch4");
    frame(3'd6, 16'h0800, "rr_ch5");
    frame(3'd0, 16'h0FFF, "rr_ch6");

    frame(3'd1, 16'h0300, "unused_pre");
    frame(3'd7, 16'h0000, "unused_ch1");
    frame(3'd0, 16'h0000, "unused_ch7");

    batt = 12'h800;
    frame(3'd6, 16'h0300, "batt_pre");
    frame(3'd6, 16'h0800, "batt_mid_change", 1'b1, 12'h900);
    frame(3'd0, 16'h0900, "batt_after_change");

    // Latch ch6 (batt=0x900), then abort the next frame after four data shifts.
    frame(3'd6, 16'h0300, "abort_pre");
    @(negedge clk);
    SS_n = 1'b0;
    repeat (16) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      SCLK = 1'b0;
      repeat (16) @(negedge clk);
      SCLK = 1'b1;
      repeat (16) @(negedge clk);
    end
    check("abort_miso_before_rst", {15'h0, MISO}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("abort_miso_in_rst", {15'h0, MISO}, 16'h0000);
    SS_n = 1'b1;
    SCLK = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_miso_after_rst", {15'h0, MISO}, 16'h0000);
    frame(3'd6, 16'h0300, "post_rst_ch0");
    frame(3'd0, 16'h0900, "post_rst_ch6");

    repeat (20) @(posedge clk);
    if (exp_q.size() != 0 || rx_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
